// File: rtl/toy_hazard_unit.sv
// toy_hazard_unit: scoreboard-based load-use stall and forwarding-select controller beside ID.
// Optional performance counters PERF_STALL/PERF_FWD are built when TOY_HAZARD_PERF_EN is defined.
module toy_hazard_unit #(
    parameter int AW         = 5,
    parameter int NRD        = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int SW         = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              ID_VALID,
    input  logic [NRD*AW-1:0] ID_RA,
    input  logic [NRD-1:0]    ID_RUSE,
    input  logic              ID_WE,
    input  logic [AW-1:0]     ID_WA,
    input  logic              ID_LOAD,
    input  logic              FLUSH,
    output logic              STALL,
    output logic [NRD*SW-1:0] FWD_SEL,
    output logic [DEPTH-1:0]  STG_VALID
`ifdef TOY_HAZARD_PERF_EN
    ,
    output logic [31:0]       PERF_STALL,
    output logic [31:0]       PERF_FWD
`endif
);

    logic [DEPTH-1:0]         v;
    logic [DEPTH-1:0]         we;
    logic [DEPTH-1:0]         ld;
    logic [DEPTH-1:0][AW-1:0] wa;
    logic [NRD-1:0]           haz;
    logic                     accept;

    assign accept    = ID_VALID & ~STALL & ~FLUSH;
    assign STALL     = |haz & ~FLUSH;
    assign STG_VALID = v;

    // Per port: scan oldest to youngest so the youngest writer of the register wins.
    always_comb begin
        haz     = '0;
        FWD_SEL = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (ID_VALID && ID_RUSE[p] && ID_RA[p*AW +: AW] != '0 &&
                    v[k] && we[k] && wa[k] == ID_RA[p*AW +: AW]) begin
                    if (ld[k] && k < LOAD_STAGE) begin
                        haz[p]              = 1'b1;
                        FWD_SEL[p*SW +: SW] = '0;
                    end else begin
                        haz[p]              = 1'b0;
                        FWD_SEL[p*SW +: SW] = SW'(k + 1);
                    end
                end
            end
        end
    end

    // Scoreboard shift: accepted ID instruction or a bubble enters stage 0.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            v  <= '0;
            we <= '0;
            ld <= '0;
            wa <= '0;
        end else begin
            v  <= {v[DEPTH-2:0], accept};
            we <= {we[DEPTH-2:0], accept & ID_WE};
            ld <= {ld[DEPTH-2:0], accept & ID_LOAD};
            wa <= {wa[DEPTH-2:0], accept ? ID_WA : AW'(0)};
        end
    end

`ifdef TOY_HAZARD_PERF_EN
    // Saturating counters of stall cycles and cycles with any forwarding.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            PERF_STALL <= '0;
            PERF_FWD   <= '0;
        end else begin
            if (STALL && PERF_STALL != 32'hFFFF_FFFF)
                PERF_STALL <= PERF_STALL + 32'd1;
            if (|FWD_SEL && PERF_FWD != 32'hFFFF_FFFF)
                PERF_FWD <= PERF_FWD + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_toy_hazard_unit.sv
// tb_toy_hazard_unit: directed literal checks plus randomized traffic against a queue-based reference model.
module tb_toy_hazard_unit;
    localparam int AW = 5, NRD = 2, DEPTH = 3, LOAD_STAGE = 1;
    localparam int SW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          v;
        logic          we;
        logic [AW-1:0] wa;
        logic          ld;
    } ent_t;

    logic              CLK = 0;
    logic              RSTN;
    logic              ID_VALID, ID_WE, ID_LOAD, FLUSH;
    logic [NRD*AW-1:0] ID_RA;
    logic [NRD-1:0]    ID_RUSE;
    logic [AW-1:0]     ID_WA;
    logic              STALL;
    logic [NRD*SW-1:0] FWD_SEL;
    logic [DEPTH-1:0]  STG_VALID;
`ifdef TOY_HAZARD_PERF_EN
    logic [31:0]       PERF_STALL, PERF_FWD;
    logic [31:0]       m_pstall, m_pfwd;
`endif

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];

    toy_hazard_unit #(.AW(AW), .NRD(NRD), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)) dut (
        .CLK(CLK), .RSTN(RSTN), .ID_VALID(ID_VALID), .ID_RA(ID_RA), .ID_RUSE(ID_RUSE),
        .ID_WE(ID_WE), .ID_WA(ID_WA), .ID_LOAD(ID_LOAD), .FLUSH(FLUSH),
        .STALL(STALL), .FWD_SEL(FWD_SEL), .STG_VALID(STG_VALID)
`ifdef TOY_HAZARD_PERF_EN
        , .PERF_STALL(PERF_STALL), .PERF_FWD(PERF_FWD)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Expected outputs from the in-flight instruction list (front = youngest = stage 0).
    function automatic void model(output logic st, output logic [NRD*SW-1:0] fs, output logic [DEPTH-1:0] sv);
        logic hz;
        hz = 1'b0;
        fs = '0;
        sv = '0;
        for (int k = 0; k < DEPTH; k++) sv[k] = mq[k].v;
        for (int p = 0; p < NRD; p++) begin
            logic [AW-1:0] r;
            r = ID_RA[p*AW +: AW];
            if (!ID_VALID || !ID_RUSE[p] || r == 0) continue;
            for (int k = 0; k < DEPTH; k++) begin
                if (mq[k].v && mq[k].we && mq[k].wa == r) begin
                    if (mq[k].ld && k < LOAD_STAGE) hz = 1'b1;
                    else fs[p*SW +: SW] = SW'(k + 1);
                    break;
                end
            end
        end
        st = hz && !FLUSH;
    endfunction

    // Reference model advance: push the accepted instruction or a bubble, retire the oldest.
    always @(posedge CLK or negedge RSTN) begin
        logic st;
        logic [NRD*SW-1:0] fs;
        logic [DEPTH-1:0] sv;
        ent_t e;
        if (!RSTN) begin
            mq = {};
            for (int k = 0; k < DEPTH; k++) mq.push_back('0);
`ifdef TOY_HAZARD_PERF_EN
            m_pstall = 0;
            m_pfwd   = 0;
`endif
        end else begin
            model(st, fs, sv);
            e = (ID_VALID && !st && !FLUSH) ? ent_t'{1'b1, ID_WE, ID_WA, ID_LOAD} : ent_t'('0);
            mq.push_front(e);
            void'(mq.pop_back());
`ifdef TOY_HAZARD_PERF_EN
            if (st && m_pstall != 32'hFFFF_FFFF) m_pstall++;
            if (fs != 0 && m_pfwd != 32'hFFFF_FFFF) m_pfwd++;
`endif
        end
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge CLK) begin
        logic st;
        logic [NRD*SW-1:0] fs;
        logic [DEPTH-1:0] sv;
        model(st, fs, sv);
        chk("stall", 32'(STALL), 32'(st));
        chk("fwd_sel", 32'(FWD_SEL), 32'(fs));
        chk("stg_valid", 32'(STG_VALID), 32'(sv));
`ifdef TOY_HAZARD_PERF_EN
        chk("perf_stall", PERF_STALL, m_pstall);
        chk("perf_fwd", PERF_FWD, m_pfwd);
`endif
    end

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] wa, input logic ld,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [1:0] ruse, input logic fl);
        ID_VALID = v;
        ID_WE    = we;
        ID_WA    = wa;
        ID_LOAD  = ld;
        ID_RA    = {r1, r0};
        ID_RUSE  = ruse;
        FLUSH    = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [SW-1:0] fsel(input int p);
        return FWD_SEL[p*SW +: SW];
    endfunction

    initial begin
        logic [31:0] ps;
        for (int k = 0; k < DEPTH; k++) mq.push_back('0);
`ifdef TOY_HAZARD_PERF_EN
        m_pstall = 0;
        m_pfwd   = 0;
`endif
        RSTN = 0;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
        #11;
        chk("reset_stg_valid", 32'(STG_VALID), 0);
        chk("reset_stall", 32'(STALL), 0);
        chk("reset_fwd", 32'(FWD_SEL), 0);
        RSTN = 1;
        drive(1, 1, 3, 0, 0, 0, 2'b00, 0);
        tick;
        drive(1, 0, 0, 0, 3, 0, 2'b01, 0);
        chk("alu_fwd_stage0", 32'(fsel(0)), 1);
        chk("alu_no_stall", 32'(STALL), 0);
        tick;
        drive(1, 0, 0, 0, 3, 0, 2'b01, 0);
        chk("alu_fwd_stage1", 32'(fsel(0)), 2);
        tick;
        drive(1, 1, 7, 1, 0, 0, 2'b00, 0);
        tick;
        drive(1, 0, 0, 0, 0, 7, 2'b10, 0);
        chk("loaduse_stall", 32'(STALL), 1);
        chk("loaduse_fwd_zero", 32'(fsel(1)), 0);
        tick;
        chk("loaduse_bubble", 32'(STG_VALID), 32'b110);
        chk("loaduse_released", 32'(STALL), 0);
        chk("loaduse_fwd_stage1", 32'(fsel(1)), 2);
        tick;
        drive(1, 1, 4, 0, 0, 0, 2'b00, 0);
        tick;
        drive(1, 1, 4, 0, 0, 0, 2'b00, 0);
        tick;
        drive(1, 0, 0, 0, 4, 4, 2'b11, 0);
        chk("shadow_port0", 32'(fsel(0)), 1);
        chk("shadow_port1", 32'(fsel(1)), 1);
        tick;
        drive(1, 1, 0, 0, 0, 0, 2'b00, 0);
        tick;
        drive(1, 0, 0, 0, 0, 0, 2'b01, 0);
        chk("r0_no_fwd", 32'(fsel(0)), 0);
        tick;
        drive(1, 1, 9, 0, 0, 0, 2'b00, 0);
        tick;
        drive(1, 0, 0, 0, 9, 0, 2'b00, 0);
        chk("ruse_mask_fwd", 32'(FWD_SEL), 0);
        chk("ruse_mask_stall", 32'(STALL), 0);
        drive(1, 0, 0, 0, 9, 0, 2'b01, 0);
        chk("ruse_on_fwd", 32'(fsel(0)), 1);
        tick;
        drive(1, 1, 7, 1, 0, 0, 2'b00, 0);
        tick;
        drive(1, 0, 0, 0, 7, 0, 2'b01, 1);
        chk("flush_no_stall", 32'(STALL), 0);
`ifdef TOY_HAZARD_PERF_EN
        ps = PERF_STALL;
`else
        ps = 0;
`endif
        tick;
        chk("flush_bubble", 32'(STG_VALID[0]), 0);
`ifdef TOY_HAZARD_PERF_EN
        chk("flush_perf_stall", PERF_STALL, ps);
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5, 0, 0, 0, 2'b00, 0);
            tick;
        end
        drive(1, 0, 0, 0, 5, 5, 2'b11, 0);
        chk("prereset_full", 32'(STG_VALID), 32'b111);
        chk("prereset_fwd", 32'(FWD_SEL), 32'b0101);
        RSTN = 0;
        #1;
        chk("midreset_stg_valid", 32'(STG_VALID), 0);
        chk("midreset_stall", 32'(STALL), 0);
        chk("midreset_fwd", 32'(FWD_SEL), 0);
        tick;
        RSTN = 1;
        #1;
        chk("postreset_stg_valid", 32'(STG_VALID), 0);
        for (int i = 0; i < 3000; i++) begin
            tick;
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, AW'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 3, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                  2'($urandom), $urandom_range(0, 7) == 0);
        end
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
